stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter TICK_DIV, default 50000000, gives the number of clk cycles per counted second (1 Hz at 50 MHz); legal range 2 to 2^26.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start_stop  input  1  single-cycle pulse, debounced upstream; toggles counting.
REQ-005 clear  input  1  single-cycle pulse; returns the count to 00:00 and stops counting.
REQ-006 lap  input  1  single-cycle pulse; toggles the display freeze (effective only with LAP_EN).
REQ-007 digit0  output  4  seconds-ones BCD, 0-9; feeds a seven-segment digit driver.
REQ-008 digit1  output  4  seconds-tens BCD, 0-5.
REQ-009 digit2  output  4  minutes-ones BCD, 0-9.
REQ-010 digit3  output  4  minutes-tens BCD, 0-5.
REQ-011 running  output  1  high while the state is RUN.
REQ-012 wrap  output  1  one-cycle pulse when the count rolls over from 59:59 to 00:00.
REQ-013 frozen  output  1  high while the display is frozen by lap (tied 0 without LAP_EN).

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, PAUSE.
REQ-015 IDLE: start_stop moves the FSM to RUN.
REQ-016 RUN: start_stop moves the FSM to PAUSE.
REQ-017 PAUSE: start_stop moves the FSM back to RUN, and the prescaler resumes from its retained value.
REQ-018 clear in any state SHALL force IDLE, zero the prescaler and all four digits, and release any freeze.
REQ-019 clear SHALL take priority over start_stop and lap when they are asserted in the same cycle.
REQ-020 The prescaler SHALL advance only in RUN.
REQ-021 When the prescaler equals TICK_DIV-1 in RUN, it SHALL return to 0 and generate a one-cycle tick.
REQ-022 On a tick, the live count SHALL increment, with updated digits visible the cycle after the tick cycle (latency 1).
REQ-023 BCD carry rules: digit0 9→0 carries to digit1; digit1 5→0 carries to digit2; digit2 9→0 carries to digit3; digit3 5→0 wraps the count.
REQ-024 The 59:59 increment SHALL produce 00:00 and assert wrap for exactly the cycle in which 00:00 first appears.
REQ-025 Counting SHALL continue after a wrap.
REQ-026 All digit outputs SHALL be registered and SHALL never hold a value above the legal range of that digit.
REQ-027 start_stop asserted in the same cycle as a tick SHALL still apply that tick's increment, with the state change taking effect in the next cycle.
REQ-028 running SHALL be a registered decode of the state, with no glitching.

Reset
REQ-029 While reset_n is low at a clk edge, the block SHALL load state IDLE, prescaler 0, all digits 0, running 0, wrap 0, frozen 0, and the lap snapshot 0.
REQ-030 Reset mid-count SHALL discard the count and all pending ticks; the first tick after release needs a start_stop pulse followed by TICK_DIV cycles in RUN.
REQ-031 All inputs SHALL be ignored in any cycle where reset_n is low.

Configuration
REQ-032 Macro STOPWATCH_LAP_EN: when defined, a lap pulse in RUN or PAUSE toggles frozen.
REQ-033 With STOPWATCH_LAP_EN defined: on the freeze, the live count is copied to a snapshot, and digit0-3 show the snapshot while the live count keeps advancing.
REQ-034 With STOPWATCH_LAP_EN defined: unfreezing shows the live count from the next cycle.
REQ-035 With STOPWATCH_LAP_EN defined: lap in IDLE has no effect, and wrap continues to pulse from the live count while frozen.
REQ-036 When STOPWATCH_LAP_EN is undefined, lap SHALL be ignored, frozen SHALL be tied 0, no snapshot registers SHALL exist, and digits always show the live count.

Verification (TICK_DIV=4)
REQ-037 Reset then start_stop, run 40 cycles -> digits 00:10, running=1.
REQ-038 Preload by running to 59:58, then 8 more RUN cycles -> 59:59 then 00:00, with wrap high for exactly 1 cycle.
REQ-039 start_stop after 2 prescaler cycles, wait 20 cycles, start_stop again -> digits unchanged during PAUSE; next tick arrives 2 cycles after resume.
REQ-040 clear and start_stop in the same cycle during RUN at 00:07 -> 00:00, state IDLE, running=0.
REQ-041 Reset_n low during RUN at 03:25 -> all outputs 0 on the next edge; no ticks until start_stop.
REQ-042 With LAP_EN: lap at 00:05, then 12 cycles -> display 00:05, frozen=1; lap again -> display 00:08.

Source files
------------

// File: rtl/stopwatch_counter.sv
// stopwatch_counter -- MM:SS stopwatch with BCD digit outputs.
//
// A prescaler divides clk by TICK_DIV to make a once-per-second tick while
// running. Each tick advances a four-digit BCD count (00:00 .. 59:59). The
// count wraps back to 00:00, pulses wrap, and keeps counting.
//
// Optional feature macro: STOPWATCH_LAP_EN. When it is defined, lap pulses
// in RUN or PAUSE freeze and unfreeze the display on a snapshot while the
// live count keeps advancing.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   start_stop  pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear       pulse: back to IDLE at 00:00, release freeze (highest priority)
//   lap         pulse: toggle display freeze (LAP_EN builds only)
//   digit0..3   seconds-ones, seconds-tens, minutes-ones, minutes-tens (BCD)
//   running     high while in RUN (registered)
//   wrap        one-cycle pulse while 00:00 first shows after 59:59
//   frozen      high while the display shows the lap snapshot
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       wrap,
  output logic       frozen
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } count_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  count_t        live, live_inc, disp;
  logic          tick, at_max;

  assign tick   = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign at_max = (live == count_t'(16'h5959));

  // FSM: state register plus registered decode for running
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // BCD ripple increment; a digit at or past its limit rolls to 0 and
  // carries, so the count can never leave its legal range.
  always_comb begin
    live_inc = live;
    if (live.s1 < 4'd9) begin
      live_inc.s1 = live.s1 + 4'd1;
    end else begin
      live_inc.s1 = 4'd0;
      if (live.s10 < 4'd5) begin
        live_inc.s10 = live.s10 + 4'd1;
      end else begin
        live_inc.s10 = 4'd0;
        if (live.m1 < 4'd9) begin
          live_inc.m1 = live.m1 + 4'd1;
        end else begin
          live_inc.m1  = 4'd0;
          live_inc.m10 = (live.m10 < 4'd5) ? live.m10 + 4'd1 : 4'd0;
        end
      end
    end
  end

  // Prescaler and live count. The prescaler only moves in RUN, so a pause
  // keeps the partial second. A tick coinciding with start_stop still counts.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      presc <= '0;
      live  <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= tick && at_max;
      if (state == RUN) presc <= tick ? '0 : presc + PW'(1);
      if (tick) live <= live_inc;
    end
  end

`ifdef STOPWATCH_LAP_EN
  count_t snap;
  logic   frz;

  // Freezing captures the count shown in the lap cycle (pre-increment if a
  // tick lands in the same cycle); unfreezing leaves snap stale but unused.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      snap <= '0;
      frz  <= 1'b0;
    end else if (lap && state != IDLE) begin
      frz <= !frz;
      if (!frz) snap <= live;
    end
  end

  assign frozen = frz;
  assign disp   = frz ? snap : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign frozen     = 1'b0;
  assign disp       = live;
`endif

  assign digit0 = disp.s1;
  assign digit1 = disp.s10;
  assign digit2 = disp.m1;
  assign digit3 = disp.m10;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter -- self-checking bench for stopwatch_counter at
// TICK_DIV=4. The reference model keeps the count as plain elapsed seconds
// and derives the expected BCD digits arithmetically.
module tb_stopwatch_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, wrap, frozen;

  int checks = 0;
  int failures = 0;

  // reference model: 0=IDLE 1=RUN 2=PAUSE
  int   m_st = 0, m_presc = 0, m_secs = 0, m_snap = 0;
  logic m_wrap = 1'b0, m_frz = 1'b0;

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear),
    .lap(lap), .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .digit3(digit3), .running(running), .wrap(wrap), .frozen(frozen)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 600), 4'((v / 60) % 10), 4'((v / 10) % 6), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_disp();
    return to_bcd(m_frz ? m_snap : m_secs);
  endfunction

  function automatic logic [15:0] dut_disp();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic model_update(input logic s, c, l, r);
    bit tk;
    if (!r || c) begin
      m_st = 0; m_presc = 0; m_secs = 0; m_wrap = 0; m_frz = 0; m_snap = 0;
    end else begin
      tk = (m_st == 1) && (m_presc == TD - 1);
`ifdef STOPWATCH_LAP_EN
      if (l && m_st != 0) begin
        if (!m_frz) m_snap = m_secs;
        m_frz = !m_frz;
      end
`endif
      m_wrap = tk && (m_secs == 3599);
      if (m_st == 1) m_presc = tk ? 0 : m_presc + 1;
      if (tk) m_secs = (m_secs + 1) % 3600;
      if (s) m_st = (m_st == 1) ? 2 : 1;
    end
  endtask

  task automatic step(input logic s, c, l, r);
    start_stop = s; clear = c; lap = l; reset_n = r;
    @(posedge clk);
    model_update(s, c, l, r);
    #1;
    start_stop = 0; clear = 0; lap = 0; reset_n = 1;
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 0);
    checks++;
    if (dut_disp() !== 16'h0000 || running !== 0 || wrap !== 0 || frozen !== 0) begin
      failures++;
      $display("FAIL reset: disp=%h run=%b wrap=%b frz=%b want 0000/0/0/0",
               dut_disp(), running, wrap, frozen);
    end
  endtask

  task automatic test_count_40();
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    run(39);
    checks++;
    if (dut_disp() !== 16'h0009) begin
      failures++; $display("FAIL count39: got %h want 0009", dut_disp());
    end
    run(1);
    checks++;
    if (dut_disp() !== 16'h0010 || running !== 1'b1) begin
      failures++;
      $display("FAIL count40: got %h run=%b want 0010 run=1", dut_disp(), running);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    run(3598 * TD);
    checks++;
    if (dut_disp() !== 16'h5958) begin
      failures++; $display("FAIL preload: got %h want 5958", dut_disp());
    end
    for (int i = 1; i <= 2 * TD; i++) begin
      run(1);
      pulses += int'(wrap);
      checks++;
      if (dut_disp() !== exp_disp() || wrap !== m_wrap) begin
        failures++;
        $display("FAIL wrap_cyc%0d: disp=%h wrap=%b want %h wrap=%b",
                 i, dut_disp(), wrap, exp_disp(), m_wrap);
      end
    end
    checks++;
    if (dut_disp() !== 16'h0000 || wrap !== 1'b1 || pulses != 1) begin
      failures++;
      $display("FAIL wrap_end: disp=%h wrap=%b pulses=%0d want 0000 1 1",
               dut_disp(), wrap, pulses);
    end
    run(TD);
    checks++;
    if (dut_disp() !== 16'h0001 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL after_wrap: disp=%h wrap=%b want 0001 0", dut_disp(), wrap);
    end
  endtask

  task automatic test_pause_resume();
    bit bad = 0;
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);          // pause with two prescaler cycles banked
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (dut_disp() !== 16'h0000 || running !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL pause_hold: disp=%h run=%b want 0000 0", dut_disp(), running);
    end
    step(1, 0, 0, 1);
    run(1);
    checks++;
    if (dut_disp() !== 16'h0000 || running !== 1'b1) begin
      failures++; $display("FAIL resume1: disp=%h run=%b want 0000 1", dut_disp(), running);
    end
    run(1);
    checks++;
    if (dut_disp() !== 16'h0001) begin
      failures++; $display("FAIL resume2: got %h want 0001", dut_disp());
    end
  endtask

  task automatic test_clear_priority();
    bit bad = 0;
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    run(7 * TD);
    checks++;
    if (dut_disp() !== 16'h0007) begin
      failures++; $display("FAIL pre_clear: got %h want 0007", dut_disp());
    end
    step(1, 1, 1, 1);
    checks++;
    if (dut_disp() !== 16'h0000 || running !== 0 || frozen !== 0) begin
      failures++;
      $display("FAIL clear_prio: disp=%h run=%b frz=%b want 0000 0 0",
               dut_disp(), running, frozen);
    end
    for (int i = 0; i < 10; i++) begin
      run(1);
      if (dut_disp() !== 16'h0000 || running !== 0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL idle_hold: disp=%h run=%b want 0000 0", dut_disp(), running);
    end
  endtask

  task automatic test_reset_midcount();
    bit bad = 0;
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    run(205 * TD);
    checks++;
    if (dut_disp() !== 16'h0325 || running !== 1'b1) begin
      failures++; $display("FAIL pre_rst: got %h run=%b want 0325 1", dut_disp(), running);
    end
    step(1, 0, 1, 0);
    checks++;
    if (dut_disp() !== 16'h0000 || running !== 0 || wrap !== 0 || frozen !== 0) begin
      failures++;
      $display("FAIL rst_mid: disp=%h run=%b wrap=%b frz=%b want 0000 0 0 0",
               dut_disp(), running, wrap, frozen);
    end
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (dut_disp() !== 16'h0000) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL rst_noticks: got %h want 0000", dut_disp());
    end
    step(1, 0, 0, 1);
    run(TD - 1);
    checks++;
    if (dut_disp() !== 16'h0000) begin
      failures++; $display("FAIL first_tick_early: got %h want 0000", dut_disp());
    end
    run(1);
    checks++;
    if (dut_disp() !== 16'h0001) begin
      failures++; $display("FAIL first_tick: got %h want 0001", dut_disp());
    end
  endtask

  task automatic test_lap();
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);          // lap in IDLE: no effect
    checks++;
    if (frozen !== 1'b0) begin
      failures++; $display("FAIL lap_idle: frozen=%b want 0", frozen);
    end
    step(1, 0, 0, 1);
    run(5 * TD);
    step(0, 0, 1, 1);
    run(12);
    checks++;
    if (dut_disp() !== exp_disp() || frozen !== m_frz) begin
      failures++;
      $display("FAIL lap_freeze: disp=%h frz=%b want %h frz=%b",
               dut_disp(), frozen, exp_disp(), m_frz);
    end
    step(0, 0, 1, 1);
    checks++;
    if (dut_disp() !== 16'h0008 || frozen !== 1'b0) begin
      failures++; $display("FAIL lap_release: disp=%h frz=%b want 0008 0", dut_disp(), frozen);
    end
`ifdef STOPWATCH_LAP_EN
    step(0, 0, 1, 1);
    run(2 * TD);
    checks++;
    if (dut_disp() !== 16'h0008 || frozen !== 1'b1 || m_secs != 10) begin
      failures++; $display("FAIL lap_refreeze: disp=%h frz=%b want 0008 1", dut_disp(), frozen);
    end
`endif
  endtask

  task automatic test_random();
    logic s, c, l, r;
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom_range(15) == 0);
      c = ($urandom_range(127) == 0);
      l = ($urandom_range(15) == 0);
      r = ($urandom_range(255) != 0);
      step(s, c, l, r);
      checks++;
      if (dut_disp() !== exp_disp() || running !== (m_st == 1) ||
          wrap !== m_wrap || frozen !== m_frz) begin
        failures++;
        $display("FAIL rand_%0d: disp=%h run=%b wrap=%b frz=%b want %h %b %b %b",
                 i, dut_disp(), running, wrap, frozen,
                 exp_disp(), (m_st == 1), m_wrap, m_frz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_40();
    test_wrap();
    test_pause_resume();
    test_clear_priority();
    test_reset_midcount();
    test_lap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
